// File: rtl/rca_sample_accumulator_if.sv
// Stream bundle for rca_sample_accumulator: sample input (valid/ready)
// and frame result output (valid/ready).
// slave  : the accumulator side (consumes samples, produces results).
// master : the producer/consumer side talking to the accumulator.
interface rca_sample_accumulator_if #(
    parameter int OVF_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [OVF_W-1:0] out_hi;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_hi, out_ovf
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_hi, out_ovf
    );
endinterface

// File: rtl/rca_sample_accumulator.sv
// rca_sample_accumulator: sequences an external 8-bit ripple-carry adder to
// sum NUM_SAMPLES stream samples per frame. The adder sees a = accumulator,
// b = incoming sample, cin = 0; its sum/carry are registered on every
// accepted sample. The finished frame (low byte, carry count, overflow flag)
// is held on the output stream until the consumer takes it.
// Optional feature macro: ACC_SATURATE_EN -- when defined, the first carry
// out of the adder pins the accumulator at 8'hFF and flags overflow instead
// of counting carries.
module rca_sample_accumulator #(
    parameter int NUM_SAMPLES = 4,
    parameter int CNT_W       = 3,
    parameter int OVF_W       = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    rca_sample_accumulator_if.slave     bus,
    output logic [7:0]                  add_a,
    output logic [7:0]                  add_b,
    output logic                        add_cin,
    input  logic [7:0]                  add_sum,
    input  logic                        add_cout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_acc;
    logic [7:0]         w_acc_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [OVF_W-1:0]   r_hi;
    logic [OVF_W-1:0]   w_hi_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_out_fire;
    logic               w_last;

    // Handshake decode: samples are refused while a result is pending.
    assign w_in_ready = (r_state != DONE);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_out_fire = (r_state == DONE) & bus.out_ready;
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_last     = (w_cnt_inc == CNT_W'(NUM_SAMPLES));

    // Adder drive: accumulator on a, live sample on b, carry-in tied low.
    assign add_a   = r_acc;
    assign add_b   = bus.in_data;
    assign add_cin = 1'b0;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_data  = r_acc;
    assign bus.out_hi    = r_hi;
    assign bus.out_ovf   = r_ovf;

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // Next-state and datapath update: hold by default, fold in a sample on
    // accept, clear everything when the result is taken.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_ovf_nxt   = r_ovf;
        if (w_out_fire) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_hi_nxt    = '0;
            w_ovf_nxt   = 1'b0;
        end else if (w_accept) begin
            w_cnt_nxt = w_cnt_inc;
`ifdef ACC_SATURATE_EN
            // Once saturated the accumulator stays pinned for the frame.
            if (r_ovf || add_cout) begin
                w_acc_nxt = 8'hFF;
                w_ovf_nxt = 1'b1;
            end else begin
                w_acc_nxt = add_sum;
            end
`else
            w_acc_nxt = add_sum;
            w_hi_nxt  = r_hi + OVF_W'(add_cout);
            // Carry counter rolling over is the only way to lose information.
            if (add_cout && (r_hi == {OVF_W{1'b1}})) begin
                w_ovf_nxt = 1'b1;
            end
`endif
            w_state_nxt = w_last ? DONE : ACCUM;
        end
    end

endmodule
